serial_frame_parser: RTL

SERIAL_FRAME_PARSER -- requirements
Module: serial_frame_parser

---
 rtl/serial_frame_parser.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_frame_parser.sv
`default_nettype none
// ============================================================================
// serial_frame_parser : SOF/CMD/LEN/payload/CHK byte-stream parser with ACK/NAK
// Revision 1.0 - initial release
// ============================================================================
module serial_frame_parser #(
  parameter logic [7:0] SOF            = 8'h41,
  parameter int         MAX_LEN        = 4,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] ACK            = 8'h06,
  parameter logic [7:0] NAK            = 8'h15
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_frame_valid,
  output logic [7:0]  o_cmd,
  output logic [2:0]  o_len,
  output logic [31:0] o_payload,
  output logic [7:0]  o_err_count,
  output logic        o_busy
);

  localparam int              TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      cmd_cand;
  logic [2:0]      len_cand;
  logic [1:0]      idx;
  logic [7:0]      acc;
  logic [31:0]     staging;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      resp_byte;

  logic            start_frame;
  logic            take_cmd;
  logic            take_len;
  logic            take_data;
  logic            chk_ok;
  logic            nak_now;
  logic            err_inc;
  logic            send;
  logic            to_run;
  logic            timed_out;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    take_cmd    = 1'b0;
    take_len    = 1'b0;
    take_data   = 1'b0;
    chk_ok      = 1'b0;
    nak_now     = 1'b0;
    err_inc     = 1'b0;
    send        = 1'b0;
    to_run      = (state == S_CMD) || (state == S_LEN) ||
                  (state == S_DATA) || (state == S_CHK);
    // A byte arriving on the final timeout cycle wins over the timeout.
    timed_out   = to_run && !i_rx_valid && (to_cnt == TO_LAST);

    case (state)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_data == SOF)) begin
          start_frame = 1'b1;
          state_nxt   = S_CMD;
        end
      end
      S_CMD: begin
        if (i_rx_valid) begin
          take_cmd  = 1'b1;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (i_rx_valid) begin
          if (i_rx_data == 8'd0) begin
            take_len  = 1'b1;
            state_nxt = S_CHK;
          end else if (i_rx_data <= MAX_LEN_B) begin
            take_len  = 1'b1;
            state_nxt = S_DATA;
          end else begin
            nak_now   = 1'b1;
            err_inc   = 1'b1;
            state_nxt = S_RESP;
          end
        end
      end
      S_DATA: begin
        if (i_rx_valid) begin
          take_data = 1'b1;
          if (({1'b0, idx} + 3'd1) == len_cand) begin
            state_nxt = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (i_rx_valid) begin
          state_nxt = S_RESP;
          if (i_rx_data == acc) begin
            chk_ok = 1'b1;
          end else begin
            nak_now = 1'b1;
            err_inc = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (!i_tx_busy) begin
          send      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (timed_out) begin
      state_nxt = S_IDLE;
      err_inc   = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_tx_data     <= 8'd0;
      o_tx_start    <= 1'b0;
      o_frame_valid <= 1'b0;
      o_cmd         <= 8'd0;
      o_len         <= 3'd0;
      o_payload     <= 32'd0;
      o_err_count   <= 8'd0;
      cmd_cand      <= 8'd0;
      len_cand      <= 3'd0;
      idx           <= 2'd0;
      acc           <= 8'd0;
      staging       <= 32'd0;
      to_cnt        <= '0;
      resp_byte     <= 8'd0;
    end else begin
      o_frame_valid <= chk_ok;
      o_tx_start    <= send;

      if (send) begin
        o_tx_data <= resp_byte;
      end
      if (chk_ok) begin
        o_cmd     <= cmd_cand;
        o_len     <= len_cand;
        o_payload <= staging;
        resp_byte <= ACK;
      end else if (nak_now) begin
        resp_byte <= NAK;
      end
      if (err_inc && (o_err_count != 8'hFF)) begin
        o_err_count <= o_err_count + 8'd1;
      end

      if (start_frame) begin
        staging <= 32'd0;
        acc     <= 8'd0;
        idx     <= 2'd0;
      end
      if (take_cmd) begin
        cmd_cand <= i_rx_data;
        acc      <= i_rx_data;
      end
      if (take_len) begin
        len_cand <= i_rx_data[2:0];
        acc      <= acc ^ i_rx_data;
        idx      <= 2'd0;
      end
      if (take_data) begin
        staging[{idx, 3'b000} +: 8] <= i_rx_data;
        acc                         <= acc ^ i_rx_data;
        idx                         <= idx + 2'd1;
      end

      if (!to_run || i_rx_valid) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_ONE;
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule
`default_nettype wire
